req_chan_slv: RTL
=================

Name: req_chan_slv

Overview:
- Slave-side receiver for the request (A) channel, directly downstream of the master request channel manager on the shared bus.
- Decodes the address window, accepts A-channel beats with a valid/ready handshake, and buffers them in a small in-order queue.
- Presents queued requests (id, addr) to the slave core through a valid/ack interface.
- The id is carried through so the response channel can return it to the issuing master.

Parameters:
- QDEPTH_LOG2, 2, log2 of queue depth (default depth 4).
- ADDR_BASE, 32'h0000_0000, base of this slave's address window.
- ADDR_MASK, 32'hF000_0000, address bits compared against ADDR_BASE.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst_n  input  1  asynchronous active-low reset.
- a_valid  input  1  request beat valid from bus.
- a_ready  output  1  slave accepts beat this cycle.
- a_id  input  4  {master id[1:0], seq[1:0]}.
- a_addr  input  32  request address.
- a_atop  input  6  atomic opcode; 0 = non-atomic.
- rq_valid  output  1  queue head valid toward slave core.
- rq_ack  input  1  slave core consumes head.
- rq_id  output  4  id of head entry.
- rq_addr  output  32  address of head entry.
- rq_err  output  1  head entry flagged (see Optional Feature).
- q_count  output  QDEPTH_LOG2+1  number of occupied entries.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - wr_ptr, rd_ptr and count are 0.
  - All storage entries are 0.
  - rq_valid=0, rq_id=0, rq_addr=0, rq_err=0, q_count=0.
  - a_ready=0, because sel is qualified by a_valid.
- Address decode: sel = a_valid & ((a_addr & ADDR_MASK) == ADDR_BASE). Beats outside the window are ignored; a_ready stays 0 for them.
- a_ready = sel & ~full. It is combinational.
  - No pass-through on full: a pop in the same cycle does not raise a_ready.
  - full = (count == 2^QDEPTH_LOG2); empty = (count == 0).
- push = a_valid & a_ready. On push:
  - entry[wr_ptr] <= {a_id, a_addr, err_bit}.
  - wr_ptr increments, wrapping modulo depth.
- pop = rq_valid & rq_ack. On pop, rd_ptr increments, wrapping modulo depth. rq_ack while empty is ignored.
- count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, and both pointers advance.
- Head outputs:
  - rq_valid = ~empty.
  - rq_id, rq_addr and rq_err are read combinationally from entry[rd_ptr].
  - The head holds stable until popped.
- Latency: a beat accepted at edge N appears on rq_* after edge N, i.e. usable in cycle N+1.
- Ordering is strict FIFO; ids are not reordered.
- Master-side contract: the master holds a_valid/a_id/a_addr stable until a_ready. The slave does not check this.
- Reset asserted mid-operation discards all queued entries immediately. No partial state survives.
- Pointer widths are QDEPTH_LOG2. Count width is QDEPTH_LOG2+1, so it holds full depth without aliasing.

Optional Feature:
- Macro: REQ_CHAN_SLV_ATOP_ERR_EN.
- Defined:
  - err_bit = |a_atop is stored per entry and presented on rq_err with the head.
  - The beat is still accepted and queued; the slave core decides how to respond.
- Undefined:
  - No err storage.
  - rq_err is tied 0.
  - a_atop is unused.

Decomposition:
- Shared package constants:
  - ID width (4), master-id width (2), addr width (32), atop width (6).
  - ATOP_NONE = 6'b000000.
- Natural sub-module: req_slv_fifo. It is a generic register-array FIFO (width, depth log2) providing push/pop/full/empty/count.
- req_chan_slv wraps it with the address decode, the a_ready logic and the err-bit packing.

Test Plan:
- Single request: a_valid=1, a_id=4'h5, a_addr=32'h0000_0100 → a_ready=1 same cycle; next cycle rq_valid=1, rq_id=5, rq_addr=0x100; rq_ack=1 → rq_valid=0, q_count=0.
- Out-of-window: a_addr=32'h1000_0000 held for 5 cycles → a_ready stays 0, q_count stays 0.
- Fill and full: 4 back-to-back beats with ids 0..3 and rq_ack=0 → q_count=4; 5th beat sees a_ready=0. Then pulse rq_ack once → next cycle a_ready=1, and FIFO order 0,1,2,3,4 is preserved on rq_id.
- Simultaneous push/pop at count=2 → q_count stays 2. Pointer wrap is checked over 10 continuous transfers with ids 0..9 mod 16, exiting in order.
- Reset mid-operation: 3 queued entries, then rst_n=0 → rq_valid=0, q_count=0, rq_id=0 with no clock edge required.
- REQ_CHAN_SLV_ATOP_ERR_EN defined: beat with a_atop=6'h21 → accepted, rq_err=1 at head. With the macro undefined, rq_err=0.

Source files
------------

// File: rtl/req_chan_slv_pkg.sv
// Shared widths and constants for the slave-side request (A) channel receiver.
package req_chan_slv_pkg;

    localparam int unsigned IdWidth     = 4;
    localparam int unsigned MidWidth    = 2;
    localparam int unsigned AddrWidth   = 32;
    localparam int unsigned AtopWidth   = 6;

    localparam logic [AtopWidth-1:0] ATOP_NONE = 6'b000000;

endpackage

// File: rtl/req_slv_fifo.sv
// Generic register-array FIFO: in-order storage with push/pop, full/empty and occupancy count.
module req_slv_fifo #(
    parameter int unsigned Width     = 8,
    parameter int unsigned DepthLog2 = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic                 pop,
    input  logic [Width-1:0]     wdata,
    output logic [Width-1:0]     rdata,
    output logic                 full,
    output logic                 empty,
    output logic [DepthLog2:0]   count
);

    localparam int unsigned Depth = 1 << DepthLog2;
    localparam logic [DepthLog2:0] CountFull = (DepthLog2 + 1)'(Depth);

    logic [Width-1:0]     mem_q [Depth];
    logic [DepthLog2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DepthLog2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DepthLog2:0]   count_q, count_d;
    logic                 do_push, do_pop;

    assign full    = (count_q == CountFull);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointers are exactly DepthLog2 bits wide, so wrap is free.
        if (do_push) wr_ptr_d = wr_ptr_q + DepthLog2'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + DepthLog2'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (DepthLog2 + 1)'(1);
            2'b01:   count_d = count_q - (DepthLog2 + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/req_chan_slv.sv
// Slave-side A-channel receiver: address-window decode, valid/ready accept, in-order request queue.
// Define REQ_CHAN_SLV_ATOP_ERR_EN to store |a_atop per entry and present it on rq_err.
module req_chan_slv
    import req_chan_slv_pkg::*;
#(
    parameter int unsigned QDEPTH_LOG2 = 2,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter logic [31:0] ADDR_MASK   = 32'hF000_0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   a_valid,
    output logic                   a_ready,
    input  logic [IdWidth-1:0]     a_id,
    input  logic [AddrWidth-1:0]   a_addr,
    input  logic [AtopWidth-1:0]   a_atop,
    output logic                   rq_valid,
    input  logic                   rq_ack,
    output logic [IdWidth-1:0]     rq_id,
    output logic [AddrWidth-1:0]   rq_addr,
    output logic                   rq_err,
    output logic [QDEPTH_LOG2:0]   q_count
);

`ifdef REQ_CHAN_SLV_ATOP_ERR_EN
    localparam int unsigned EntryWidth = IdWidth + AddrWidth + 1;
`else
    localparam int unsigned EntryWidth = IdWidth + AddrWidth;
`endif

    logic                  sel, full, empty, push, pop;
    logic [EntryWidth-1:0] wdata, rdata;

    assign sel      = a_valid & ((a_addr & ADDR_MASK) == ADDR_BASE);
    // No pass-through: a pop in the same cycle never frees a slot for this beat.
    assign a_ready  = sel & ~full;
    assign push     = a_valid & a_ready;
    assign rq_valid = ~empty;
    assign pop      = rq_valid & rq_ack;

`ifdef REQ_CHAN_SLV_ATOP_ERR_EN
    assign wdata              = {a_id, a_addr, (a_atop != ATOP_NONE)};
    assign {rq_id, rq_addr}   = rdata[EntryWidth-1:1];
    assign rq_err             = rdata[0];
`else
    logic unused_atop;
    assign unused_atop        = ^a_atop;
    assign wdata              = {a_id, a_addr};
    assign {rq_id, rq_addr}   = rdata;
    assign rq_err             = 1'b0;
`endif

    req_slv_fifo #(
        .Width     (EntryWidth),
        .DepthLog2 (QDEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .count (q_count)
    );

endmodule
